// File: rtl/ifetch_stage.sv
// Minisys instruction fetch stage: owns the PC, fetches over a variable-latency
// imem handshake and selects the next PC. Optional feature macro: IFETCH_ALIGN_CHECK_EN.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instruction,
  output logic [31:0]       PC_plus_4,
  output logic [31:0]       opcplus4,
  output logic              instr_valid,
  input  logic [31:0]       Addr_result,
  input  logic [31:0]       Read_data_1,
  input  logic              Zero,
  input  logic              Branch,
  input  logic              nBranch,
  input  logic              Jmp,
  input  logic              Jal,
  input  logic              Jr
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_err
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    HALT  = 2'd2
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] pc_d;
  logic        pc_load;
  logic        branch_taken;
  logic        fetch_done;

  assign PC_plus_4    = pc + 32'd4;
  assign branch_taken = (Branch & Zero) | (nBranch & ~Zero);
  assign fetch_done   = (state == FETCH) && imem_ack;

  always_comb begin
    next_pc = PC_plus_4;
    if (Jr)
      next_pc = Read_data_1;
    else if (Jmp || Jal)
      next_pc = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
    else if (branch_taken)
      next_pc = Addr_result;
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |next_pc[1:0];
  assign pc_d       = next_pc;
  assign pc_load    = (state == EXEC) && !misaligned;
`else
  // Without the check a misaligned target is silently rounded down to a word.
  assign pc_d    = next_pc & 32'hFFFF_FFFC;
  assign pc_load = (state == EXEC);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= FETCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (imem_ack) state_nxt = EXEC;
`ifdef IFETCH_ALIGN_CHECK_EN
      EXEC:  state_nxt = misaligned ? HALT : FETCH;
      HALT:  state_nxt = HALT;
`else
      EXEC:  state_nxt = FETCH;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  // Request is gated by reset so an abandoned fetch drops the request at once.
  always_comb begin
    imem_req    = (state == FETCH) && reset;
    instr_valid = (state == EXEC);
    imem_addr   = pc[ADDR_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      pc <= RESET_PC;
    else if (pc_load)
      pc <= pc_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Instruction <= 32'h0;
      opcplus4    <= 32'h0;
    end else if (fetch_done) begin
      Instruction <= imem_rdata;
      opcplus4    <= PC_plus_4;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      fetch_err <= 1'b0;
    else if ((state == EXEC) && misaligned)
      fetch_err <= 1'b1;
  end
`endif

  a_req_valid_exclusive: assert property (
    @(posedge clock) disable iff (!reset) !(imem_req && instr_valid));
  a_valid_single_cycle: assert property (
    @(posedge clock) disable iff (!reset) instr_valid |=> !instr_valid);

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage with a wait-state imem model.
// Build with IFETCH_ALIGN_CHECK_EN defined to exercise the alignment trap.
module tb_ifetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction, PC_plus_4, opcplus4;
  logic        instr_valid;
  logic [31:0] Addr_result = 32'h0;
  logic [31:0] Read_data_1 = 32'h0;
  logic        Zero = 1'b0, Branch = 1'b0, nBranch = 1'b0;
  logic        Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] rom [logic [15:0]];
  int          wait_cycles = 0;
  int          wcnt = 0;
  bit          mem_auto = 1'b1;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [5:0]  ctl;
    logic [31:0] rd1;
    logic [31:0] ares;
  } step_t;
  step_t steps [10];

  ifetch_stage dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .PC_plus_4(PC_plus_4), .opcplus4(opcplus4),
    .instr_valid(instr_valid),
    .Addr_result(Addr_result), .Read_data_1(Read_data_1), .Zero(Zero),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .fetch_err(fetch_err)
`endif
  );

  always #5 clock = ~clock;

  assign imem_ack   = mem_auto ? auto_ack : man_ack;
  assign imem_rdata = mem_auto ? auto_rdata : man_rdata;

  function automatic logic [31:0] rom_read(input logic [15:0] a);
    return rom.exists(a) ? rom[a] : 32'h0;
  endfunction

  // Memory responder: acks after wait_cycles request cycles, garbage data otherwise.
  initial begin
    forever begin
      @(negedge clock);
      if (imem_req) begin
        if (wcnt >= wait_cycles) begin
          auto_ack   = 1'b1;
          auto_rdata = rom_read(imem_addr);
          wcnt       = 0;
        end else begin
          auto_ack   = 1'b0;
          auto_rdata = 32'hBAD0_BAD0;
          wcnt++;
        end
      end else begin
        auto_ack   = 1'b0;
        auto_rdata = 32'hBAD0_BAD0;
        wcnt       = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_ctl();
    {Jr, Jmp, Jal, Branch, nBranch, Zero} = 6'b0;
    Read_data_1 = 32'h0;
    Addr_result = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    compared++;
    if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
    compared++;
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    compared++;
    if (Instruction !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr: got %h expected 0", Instruction); end
    compared++;
    if (opcplus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_opcplus4: got %h expected 0", opcplus4); end
    compared++;
    if (imem_addr !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_addr); end
`ifdef IFETCH_ALIGN_CHECK_EN
    compared++;
    if (fetch_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fetch_err: got %b expected 0", fetch_err); end
`endif
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    compared++;
    if (imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_release_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      compared++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(4 * k) || instr_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL zw_fetch%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                 k, imem_req, imem_addr, instr_valid, 16'(4 * k));
      end
      @(negedge clock);
      compared++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || Instruction !== 32'h0) begin
        mismatched++;
        $display("[TB] FAIL zw_exec%0d: got valid=%b req=%b instr=%h expected 1 0 00000000",
                 k, instr_valid, imem_req, Instruction);
      end
      if (k == 0) begin
        compared++;
        if (PC_plus_4 !== 32'h4 || opcplus4 !== 32'h4) begin
          mismatched++;
          $display("[TB] FAIL zw_pc4: got pc4=%h opc=%h expected 4 4", PC_plus_4, opcplus4);
        end
      end
    end
  endtask

  task automatic test_jump_branch();
    steps[0] = '{16'h0010, 32'h0C00_0040, 32'h0000_0014, 6'b001000, 32'h0, 32'h0};
    steps[1] = '{16'h0100, 32'h1000_0033, 32'h0000_0104, 6'b000101, 32'h0, 32'h200};
    steps[2] = '{16'h0200, 32'h2442_0001, 32'h0000_0204, 6'b100000, 32'h100, 32'h0};
    steps[3] = '{16'h0100, 32'h1000_0033, 32'h0000_0104, 6'b000100, 32'h0, 32'h200};
    steps[4] = '{16'h0104, 32'h1400_0005, 32'h0000_0108, 6'b000010, 32'h0, 32'h40};
    steps[5] = '{16'h0040, 32'h0000_0000, 32'h0000_0044, 6'b100101, 32'h80, 32'h300};
    steps[6] = '{16'h0080, 32'h0800_0030, 32'h0000_0084, 6'b010101, 32'h0, 32'h300};
    steps[7] = '{16'h00C0, 32'h0000_0000, 32'h0000_00C4, 6'b100000, 32'hFFFF_FFFC, 32'h0};
    steps[8] = '{16'hFFFC, 32'h0000_0000, 32'h0000_0000, 6'b000000, 32'h0, 32'h0};
    steps[9] = '{16'h0000, 32'h0000_0000, 32'h0000_0004, 6'b000000, 32'h0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      clear_ctl();
      compared++;
      if (imem_req !== 1'b1 || imem_addr !== steps[i].addr) begin
        mismatched++;
        $display("[TB] FAIL jb_fetch%0d: got req=%b addr=%h expected req=1 addr=%h",
                 i, imem_req, imem_addr, steps[i].addr);
      end
      @(negedge clock);
      compared++;
      if (instr_valid !== 1'b1 || Instruction !== steps[i].instr ||
          PC_plus_4 !== steps[i].pc4 || opcplus4 !== steps[i].pc4) begin
        mismatched++;
        $display("[TB] FAIL jb_exec%0d: got valid=%b instr=%h pc4=%h opc=%h expected 1 %h %h %h",
                 i, instr_valid, Instruction, PC_plus_4, opcplus4,
                 steps[i].instr, steps[i].pc4, steps[i].pc4);
      end
      {Jr, Jmp, Jal, Branch, nBranch, Zero} = steps[i].ctl;
      Read_data_1 = steps[i].rd1;
      Addr_result = steps[i].ares;
    end
  endtask

  task automatic test_align();
    @(negedge clock);
    clear_ctl();
    compared++;
    if (imem_addr !== 16'h0004) begin mismatched++; $display("[TB] FAIL al_fetch: got %h expected 0004", imem_addr); end
    @(negedge clock);
    Jr = 1'b1;
    Read_data_1 = 32'h82;
    @(negedge clock);
    clear_ctl();
`ifdef IFETCH_ALIGN_CHECK_EN
    compared++;
    if (fetch_err !== 1'b1) begin mismatched++; $display("[TB] FAIL al_fetch_err: got %b expected 1", fetch_err); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 16'h0004) begin
        mismatched++;
        $display("[TB] FAIL al_halt%0d: got req=%b valid=%b addr=%h expected 0 0 0004",
                 i, imem_req, instr_valid, imem_addr);
      end
      @(negedge clock);
    end
    do_reset();
    #1;
    compared++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL al_recover: got err=%b req=%b expected 0 1", fetch_err, imem_req);
    end
`else
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
      mismatched++;
      $display("[TB] FAIL al_round: got req=%b addr=%h expected 1 0080", imem_req, imem_addr);
    end
    @(negedge clock);
    compared++;
    if (PC_plus_4 !== 32'h84) begin mismatched++; $display("[TB] FAIL al_pc4: got %h expected 84", PC_plus_4); end
`endif
  endtask

  task automatic test_wait_states();
    int  req_cycles = 0;
    int  cyc = 1;
    bit  got = 1'b0;
    bit  addr_bad = 1'b0;
    wait_cycles = 3;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (instr_valid) begin got = 1'b1; break; end
      if (imem_req) begin
        req_cycles++;
        if (imem_addr !== 16'h0) addr_bad = 1'b1;
      end
    end
    compared++;
    if (!got || req_cycles != 4 || addr_bad || Instruction !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL ws_first: got seen=%b req_cycles=%0d addr_bad=%b instr=%h expected 1 4 0 0",
               got, req_cycles, addr_bad, Instruction);
    end
    @(negedge clock);
    compared++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h4) begin
      mismatched++;
      $display("[TB] FAIL ws_single: got valid=%b req=%b addr=%h expected 0 1 0004",
               instr_valid, imem_req, imem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      cyc++;
      if (instr_valid) begin got = 1'b1; break; end
    end
    compared++;
    if (!got || cyc != 5) begin
      mismatched++;
      $display("[TB] FAIL ws_period: got seen=%b period=%0d expected 1 5", got, cyc);
    end
    wait_cycles = 0;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    @(negedge clock);
    @(negedge clock);
    mem_auto = 1'b0;
    man_ack  = 1'b0;
    @(negedge clock);
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h4) begin
      mismatched++;
      $display("[TB] FAIL mf_pre: got req=%b addr=%h expected 1 0004", imem_req, imem_addr);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL mf_drop: got req=%b addr=%h expected 0 0000", imem_req, imem_addr);
    end
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clock);
    #1;
    compared++;
    if (Instruction !== 32'h0 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mf_stale: got instr=%h valid=%b expected 0 0", Instruction, instr_valid);
    end
    man_ack = 1'b0;
    #1 reset = 1'b1;
    @(negedge clock);
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0 || Instruction !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL mf_restart: got req=%b addr=%h instr=%h expected 1 0000 0",
               imem_req, imem_addr, Instruction);
    end
    man_ack   = 1'b1;
    man_rdata = 32'h1234_5678;
    @(negedge clock);
    compared++;
    if (instr_valid !== 1'b1 || Instruction !== 32'h1234_5678 || opcplus4 !== 32'h4) begin
      mismatched++;
      $display("[TB] FAIL mf_load: got valid=%b instr=%h opc=%h expected 1 12345678 4",
               instr_valid, Instruction, opcplus4);
    end
    man_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    man_ack = 1'b0;
    compared++;
    if (Instruction !== 32'h1234_5678 || imem_addr !== 16'h4 || imem_req !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mf_exec_ack: got instr=%h addr=%h req=%b expected 12345678 0004 1",
               Instruction, imem_addr, imem_req);
    end
    mem_auto = 1'b1;
  endtask

  initial begin
    rom[16'h0010] = 32'h0C00_0040;
    rom[16'h0100] = 32'h1000_0033;
    rom[16'h0104] = 32'h1400_0005;
    rom[16'h0200] = 32'h2442_0001;
    rom[16'h0080] = 32'h0800_0030;
    $display("[TB] starting ifetch_stage bench");
    test_reset();
    test_zero_wait();
    test_jump_branch();
    test_align();
    test_wait_states();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
